// File: rtl/ysyx_24100029_axi_master.sv
// Single-outstanding AXI4 master: one core request becomes one single-beat AXI read or write.
// Define YSYX_24100029_AXI_MASTER_TIMEOUT_EN to enable the TIMEOUT_CYCLES watchdog.
module ysyx_24100029_axi_master #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  input  logic [2:0]  req_size,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  output logic [3:0]  arid,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  input  logic        rlast,
  input  logic [3:0]  rid,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  awid,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  output logic        wlast,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  input  logic [3:0]  bid,
  output logic [2:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
  // a valid, once raised, stays high with a frozen payload until that edge.

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WRITE = 3'd3,
    WRESP = 3'd4,
    RSP   = 3'd5
  } state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [2:0]  size_q;
  logic        aw_left;
  logic        w_left;

`ifdef YSYX_24100029_AXI_MASTER_TIMEOUT_EN
  logic [31:0] timer_q;
`endif

  assign aw_left = awvalid & ~awready;
  assign w_left  = wvalid & ~wready;

  assign araddr  = addr_q;
  assign arid    = 4'd0;
  assign arlen   = 8'd0;
  assign arsize  = size_q;
  assign arburst = 2'b01;
  assign awaddr  = addr_q;
  assign awid    = 4'd0;
  assign awlen   = 8'd0;
  assign awsize  = size_q;
  assign awburst = 2'b01;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = wvalid;
  assign dbg_state = state;

  logic unused_ok;
  assign unused_ok = ^{rid, rlast, bid, rresp[0], bresp[0], 32'(TIMEOUT_CYCLES)};

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      size_q    <= 3'd0;
`ifdef YSYX_24100029_AXI_MASTER_TIMEOUT_EN
      timer_q   <= 32'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            wstrb_q   <= req_wstrb;
            size_q    <= req_size;
            req_ready <= 1'b0;
            if (req_wen) begin
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= WRITE;
            end else begin
              arvalid <= 1'b1;
              state   <= RADDR;
            end
          end
        end
        RADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RDATA;
          end
        end
        RDATA: begin
          if (rvalid) begin
            rready    <= 1'b0;
            rsp_rdata <= rdata;
            rsp_err   <= rresp[1];
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
        end
        WRITE: begin
          // AW and W retire independently; move on once neither is still pending.
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          if (!aw_left && !w_left) begin
            bready <= 1'b1;
            state  <= WRESP;
          end
        end
        WRESP: begin
          if (bvalid) begin
            bready    <= 1'b0;
            rsp_err   <= bresp[1];
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
        end
        RSP: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase

`ifdef YSYX_24100029_AXI_MASTER_TIMEOUT_EN
      // Watchdog overrides whatever the case statement decided this edge.
      if (state == IDLE) begin
        timer_q <= 32'd0;
      end else if (state != RSP) begin
        if (timer_q == 32'(TIMEOUT_CYCLES - 1)) begin
          arvalid   <= 1'b0;
          rready    <= 1'b0;
          awvalid   <= 1'b0;
          wvalid    <= 1'b0;
          bready    <= 1'b0;
          rsp_err   <= 1'b1;
          rsp_rdata <= 32'd0;
          rsp_valid <= 1'b1;
          state     <= RSP;
        end else begin
          timer_q <= timer_q + 32'd1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_ysyx_24100029_axi_master.sv
// Bench for ysyx_24100029_axi_master: table vectors, randomized transactions against a
// cycle-count model of a responsive AXI slave, and hand-written reset/stall/spurious sequences.
module tb_ysyx_24100029_axi_master;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic [2:0]  req_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready, rlast;
  logic [3:0]  rid;
  logic [31:0] awaddr;
  logic        awvalid, awready;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready, wlast;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [3:0]  bid;
  logic [2:0]  dbg_state;

  always #5 clock = ~clock;

  ysyx_24100029_axi_master #(.TIMEOUT_CYCLES(64)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_size(req_size),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready), .rlast(rlast), .rid(rid),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .awid(awid),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready), .wlast(wlast),
    .bresp(bresp), .bvalid(bvalid), .bready(bready), .bid(bid),
    .dbg_state(dbg_state)
  );

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [2:0]  size;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [1:0]  bresp;
    int          ar_d, r_d, aw_d, w_d, b_d;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  logic [32:0] exp_q[$];
  logic [31:0] model_rdata = 32'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0; req_size = 0;
    arready = 0; rdata = 0; rresp = 0; rvalid = 0; rlast = 0; rid = 0;
    awready = 0; wready = 0; bresp = 0; bvalid = 0; bid = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 0;
    model_rdata = 32'd0;
    exp_q.delete();
  endtask

  // One transaction against a slave that waits the given number of cycles on each channel.
  task automatic run_txn(input vec_t v, input logic [31:0] exp_rdata, input logic exp_err, input string tag);
    bit ar_done, r_done, aw_done, w_done, b_done, post;
    int ar_w, r_w, aw_w, w_w, b_w, lat, start_err;
    logic e_arv, e_rr, e_awv, e_wv, e_br, e_rsp;
    logic [32:0] e;
    ar_done = 0; r_done = 0; aw_done = 0; w_done = 0; b_done = 0; post = 0;
    ar_w = 0; r_w = 0; aw_w = 0; w_w = 0; b_w = 0;
    start_err = n_err;
    lat = v.wen ? 3 + ((v.aw_d > v.w_d) ? v.aw_d : v.w_d) + v.b_d : 3 + v.ar_d + v.r_d;
    req_wen = v.wen; req_addr = v.addr; req_wdata = v.wdata; req_wstrb = v.wstrb; req_size = v.size;
    exp_q.push_back({exp_err, exp_rdata});
    for (int c = 0; c <= lat + 1; c++) begin
      if (post) begin
        check({tag, "_after_rsp"}, {req_ready, arvalid, rready, awvalid, wvalid, wlast, bready, rsp_valid}, 8'b1000_0000);
        break;
      end
      e_arv = !v.wen && c >= 1 && !ar_done;
      e_rr  = !v.wen && ar_done && !r_done;
      e_awv = v.wen && c >= 1 && !aw_done;
      e_wv  = v.wen && c >= 1 && !w_done;
      e_br  = v.wen && aw_done && w_done && !b_done;
      e_rsp = (c == lat);
      check({tag, "_ctrl"}, {req_ready, arvalid, rready, awvalid, wvalid, wlast, bready, rsp_valid},
            {c == 0, e_arv, e_rr, e_awv, e_wv, e_wv, e_br, e_rsp});
      if (e_arv)
        check({tag, "_ar_payload"}, {araddr, arsize, arlen, arburst, arid}, {v.addr, v.size, 8'd0, 2'b01, 4'd0});
      if (e_awv)
        check({tag, "_aw_payload"}, {awaddr, awsize, awlen, awburst, awid}, {v.addr, v.size, 8'd0, 2'b01, 4'd0});
      if (e_wv)
        check({tag, "_w_payload"}, {wdata, wstrb}, {v.wdata, v.wstrb});
      if (e_rsp) begin
        e = exp_q.pop_front();
        check({tag, "_rsp"}, {rsp_err, rsp_rdata}, e);
        post = 1;
      end
      req_valid = (c == 0);
      arready = e_arv && ar_w >= v.ar_d;
      awready = e_awv && aw_w >= v.aw_d;
      wready  = e_wv && w_w >= v.w_d;
      rvalid  = e_rr && r_w >= v.r_d;
      rdata   = rvalid ? v.rdata : $urandom;
      rresp   = rvalid ? v.rresp : 2'(($urandom_range(0, 3)));
      rid     = 4'($urandom_range(0, 15));
      rlast   = rvalid;
      bvalid  = e_br && b_w >= v.b_d;
      bresp   = bvalid ? v.bresp : 2'(($urandom_range(0, 3)));
      if (e_arv) begin if (arready) ar_done = 1; else ar_w++; end
      if (e_rr)  begin if (rvalid)  r_done  = 1; else r_w++;  end
      if (e_awv) begin if (awready) aw_done = 1; else aw_w++; end
      if (e_wv)  begin if (wready)  w_done  = 1; else w_w++;  end
      if (e_br)  begin if (bvalid)  b_done  = 1; else b_w++;  end
      @(posedge clock); #1;
    end
    idle_inputs();
    model_rdata = exp_rdata;
    if (n_err != start_err) do_reset();
  endtask

  vec_t tab[6];
  vec_t rv;
  int   pulses;
  logic seen_err;
  logic [31:0] seen_data;

  initial begin
    tab[0] = '{0, 32'h0200_0000, 32'h0, 4'h0, 3'd2, 32'h1234_5678, 2'b00, 2'b00, 0, 0, 0, 0, 0, 32'h1234_5678, 1'b0};
    tab[1] = '{1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b0011, 3'd2, 32'h0, 2'b00, 2'b10, 0, 0, 0, 3, 0, 32'h1234_5678, 1'b1};
    tab[2] = '{0, 32'h0000_1000, 32'h0, 4'h0, 3'd0, 32'hA5A5_0001, 2'b01, 2'b00, 10, 2, 0, 0, 0, 32'hA5A5_0001, 1'b0};
    tab[3] = '{0, 32'h0000_2004, 32'h0, 4'h0, 3'd2, 32'hCAFE_F00D, 2'b11, 2'b00, 0, 5, 0, 0, 0, 32'hCAFE_F00D, 1'b1};
    tab[4] = '{1, 32'h0000_3000, 32'h1111_2222, 4'b1111, 3'd2, 32'h0, 2'b00, 2'b01, 0, 0, 4, 0, 2, 32'hCAFE_F00D, 1'b0};
    tab[5] = '{1, 32'h0000_3008, 32'h3333_4444, 4'b1100, 3'd1, 32'h0, 2'b00, 2'b11, 0, 0, 2, 2, 0, 32'hCAFE_F00D, 1'b1};

    do_reset();
    check("reset_ctrl", {req_ready, arvalid, rready, awvalid, wvalid, wlast, bready, rsp_valid}, 8'b1000_0000);
    check("reset_rsp", {rsp_err, rsp_rdata, dbg_state}, 36'd0);

    for (int i = 0; i < 6; i++)
      run_txn(tab[i], tab[i].exp_rdata, tab[i].exp_err, $sformatf("tab%0d", i));

    for (int i = 0; i < 40; i++) begin
      rv.wen   = 1'($urandom_range(0, 1));
      rv.addr  = $urandom;
      rv.wdata = $urandom;
      rv.wstrb = 4'($urandom_range(0, 15));
      rv.size  = 3'($urandom_range(0, 2));
      rv.rdata = $urandom;
      rv.rresp = 2'($urandom_range(0, 3));
      rv.bresp = 2'($urandom_range(0, 3));
      rv.ar_d = $urandom_range(0, 4); rv.r_d = $urandom_range(0, 4);
      rv.aw_d = $urandom_range(0, 4); rv.w_d = $urandom_range(0, 4); rv.b_d = $urandom_range(0, 4);
      rv.exp_rdata = rv.wen ? model_rdata : rv.rdata;
      rv.exp_err   = rv.wen ? rv.bresp[1] : rv.rresp[1];
      run_txn(rv, rv.exp_rdata, rv.exp_err, $sformatf("rnd%0d", i));
    end

    // Spurious response-channel valids while idle must be ignored.
    bvalid = 1; rvalid = 1; bresp = 2'b10; rresp = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check("spurious_ctrl", {req_ready, arvalid, rready, awvalid, wvalid, wlast, bready, rsp_valid, dbg_state},
            {8'b1000_0000, 3'd0});
    end
    idle_inputs();

    // Reset while waiting for a write response abandons the transaction.
    req_valid = 1; req_wen = 1; req_addr = 32'h4000_0000; req_wdata = 32'h5555_AAAA; req_wstrb = 4'hF; req_size = 3'd2;
    @(posedge clock); #1;
    req_valid = 0; awready = 1; wready = 1;
    @(posedge clock); #1;
    awready = 0; wready = 0;
    check("wresp_bready", {bready, dbg_state}, {1'b1, 3'd4});
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
    model_rdata = 32'd0;
    check("wresp_reset_ctrl", {req_ready, arvalid, rready, awvalid, wvalid, wlast, bready, rsp_valid, dbg_state},
          {8'b1000_0000, 3'd0});
    rv = '{0, 32'h0200_0040, 32'h0, 4'h0, 3'd2, 32'h0BAD_CAFE, 2'b00, 2'b00, 0, 0, 0, 0, 0, 32'h0BAD_CAFE, 1'b0};
    run_txn(rv, rv.exp_rdata, rv.exp_err, "post_reset");

    // Read whose data never arrives.
    req_valid = 1; req_wen = 0; req_addr = 32'h3000_0000; req_size = 3'd2;
    @(posedge clock); #1;
    req_valid = 0; arready = 1;
    @(posedge clock); #1;
    arready = 0;
    pulses = 0; seen_err = 0; seen_data = 32'hFFFF_FFFF;
    for (int i = 0; i < 1000; i++) begin
      if (rsp_valid) begin
        pulses++; seen_err = rsp_err; seen_data = rsp_rdata;
      end
      @(posedge clock); #1;
    end
`ifdef YSYX_24100029_AXI_MASTER_TIMEOUT_EN
    check("timeout_pulses", 64'(pulses), 64'd1);
    check("timeout_rsp", {seen_err, seen_data}, {1'b1, 32'd0});
`else
    check("stall_pulses", 64'(pulses), 64'd0);
    check("stall_state", {rready, dbg_state}, {1'b1, 3'd2});
`endif
    do_reset();
    check("final_reset", {req_ready, rready, rsp_valid, dbg_state}, {3'b100, 3'd0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_24100029_axi_master.md
YSYX_24100029_AXI_MASTER -- requirements
Module: ysyx_24100029_axi_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: watchdog limit in cycles; used only when YSYX_24100029_AXI_MASTER_TIMEOUT_EN is defined.
REQ-002 Port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1: synchronous, active-high reset.
REQ-004 Ports req_valid (input, 1) and req_ready (output, 1): core request handshake.
REQ-005 Ports req_wen (input, 1), req_addr (input, 32), req_wdata (input, 32), req_wstrb (input, 4), req_size (input, 3): write-enable, address, write data, byte strobes, AXI size code.
REQ-006 Ports rsp_valid (output, 1), rsp_rdata (output, 32), rsp_err (output, 1): completion pulse, read data, error flag.
REQ-007 Ports araddr (output, 32), arvalid (output, 1), arready (input, 1), arid (output, 4), arlen (output, 8), arsize (output, 3), arburst (output, 2): AXI4 read-address channel.
REQ-008 Ports rdata (input, 32), rresp (input, 2), rvalid (input, 1), rready (output, 1), rlast (input, 1), rid (input, 4): AXI4 read-data channel.
REQ-009 Ports awaddr (output, 32), awvalid (output, 1), awready (input, 1), awid (output, 4), awlen (output, 8), awsize (output, 3), awburst (output, 2): AXI4 write-address channel.
REQ-010 Ports wdata (output, 32), wstrb (output, 4), wvalid (output, 1), wready (input, 1), wlast (output, 1): AXI4 write-data channel.
REQ-011 Ports bresp (input, 2), bvalid (input, 1), bready (output, 1), bid (input, 4): AXI4 write-response channel.

Function
REQ-012 The FSM SHALL have states IDLE, RADDR, RDATA, WRITE, WRESP, RSP.
REQ-013 req_ready SHALL be 1 only in IDLE; a request is accepted on the cycle req_valid & req_ready.
REQ-014 On acceptance the block SHALL latch addr, wdata, wstrb, size and wen, then enter RADDR (wen=0) or WRITE (wen=1).
REQ-015 arid/awid SHALL be 0, arlen/awlen 0, arburst/awburst 2'b01, arsize/awsize the latched size, wlast equal to wvalid.
REQ-016 In RADDR, arvalid SHALL be 1 with araddr stable; on arvalid & arready go to RDATA.
REQ-017 In RDATA, rready SHALL be 1; on rvalid, latch rdata into rsp_rdata and rresp[1] into rsp_err, then go to RSP; rid and rlast are ignored.
REQ-018 On entering WRITE, awvalid and wvalid SHALL both be 1; each drops independently after its own handshake, in either order or the same cycle.
REQ-019 When both AW and W handshakes are complete, the FSM SHALL go to WRESP with bready=1; on bvalid, latch bresp[1] into rsp_err, leave rsp_rdata unchanged, go to RSP.
REQ-020 In RSP, rsp_valid SHALL be 1 for exactly one cycle, then the FSM returns to IDLE; rsp_rdata/rsp_err hold until the next completion.
REQ-021 Minimum latency: accept at cycle T, arvalid at T+1, and rsp_valid at T+3 when arready and rvalid are each asserted on their first possible cycle; the same figure applies to writes.
REQ-022 arvalid, awvalid and wvalid SHALL not be withdrawn before their handshake, and their payload SHALL not change while valid.
REQ-023 rvalid or bvalid arriving in any state other than RDATA/WRESP SHALL be ignored (rready=bready=0).

Reset
REQ-024 While reset is 1 at a clock edge: state IDLE; arvalid, awvalid, wvalid, rready, bready, rsp_valid, rsp_err = 0; rsp_rdata = 0.
REQ-025 Reset asserted mid-transaction SHALL abandon it, with no rsp_valid, and all valids low from the next edge.

Configuration
REQ-026 Macro YSYX_24100029_AXI_MASTER_TIMEOUT_EN defined: a cycle counter clears on acceptance and counts in RADDR/RDATA/WRITE/WRESP.
REQ-027 When that counter reaches TIMEOUT_CYCLES, all valids/readies SHALL drop and the FSM SHALL enter RSP with rsp_err=1 and rsp_rdata=0.
REQ-028 Macro not defined: no counter exists and the block waits indefinitely in each state.

Verification
REQ-029 Read: req addr 0x0200_0000, size 2; arready=1, rvalid at the first cycle with rdata 0x1234_5678, rresp 0 -> rsp_valid at T+3, rsp_rdata 0x1234_5678, rsp_err 0.
REQ-030 Write: addr 0x8000_0010, wdata 0xDEAD_BEEF, wstrb 4'b0011; awready 3 cycles before wready, bresp 2'b10 -> wlast=1 with wvalid, awvalid/wvalid drop independently, rsp_err 1.
REQ-031 Back-pressure: arready held low 10 cycles -> arvalid and araddr stable throughout, req_ready 0 throughout.
REQ-032 Reset asserted while in WRESP -> next edge: IDLE, bready 0, no rsp_valid; a new request is accepted next cycle.
REQ-033 Timeout (macro defined, TIMEOUT_CYCLES=8): rvalid never asserted -> rsp_valid with rsp_err 1 and rsp_rdata 0 after 8 cycles; without the macro, no rsp_valid after 1000 cycles.
REQ-034 Spurious bvalid pulse in IDLE -> bready 0, state unchanged, no rsp_valid.
